bf16_add_operand_stage: RTL and testbench

- Registered, handshaked operand stage directly upstream of the combinational bf16 adder.
- Accepts raw bf16 word pairs and unpacks each into sign/exponent/mantissa fields.
- Flushes subnormals to signed zero and optionally resolves special-operand results (zero/inf/NaN) so the adder datapath only ever sees normal numbers.
- Uses a 2-entry skid buffer, so `ready_o` is a flop output and never combinationally depends on `ready_i`.

---
 rtl/bf16_pkg.sv | 26 ++
 rtl/bf16_classify.sv | 42 ++++
 rtl/bf16_add_operand_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_bf16_add_operand_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// bf16_pkg
// Shared definitions for the bf16 adder operand path.
//   BF16_E / BF16_M  : exponent and stored-mantissa widths of a bf16 word
//   BF16_CANON_NAN   : canonical quiet NaN produced for invalid operations
//   bf16_op_t        : unpacked operand {s, e, m}
//   skid_state_t     : occupancy of the 2-entry skid buffer
package bf16_pkg;

    localparam int BF16_E = 8;
    localparam int BF16_M = 7;

    localparam logic [BF16_E+BF16_M:0] BF16_CANON_NAN = 16'h7FC0;

    typedef struct packed {
        logic              s;
        logic [BF16_E-1:0] e;
        logic [BF16_M-1:0] m;
    } bf16_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/bf16_classify.sv
// bf16_classify
// Combinational decode of one raw bf16 word.
// Ports:
//   word    : raw operand {s, e, m}
//   s, e, m : unpacked fields; m is forced to 0 when e == 0 (subnormal flush)
//   is_zero : exact zero (e == 0, m == 0)
//   is_sub  : subnormal (e == 0, m != 0), flushed to signed zero
//   is_inf  : e all-ones, m == 0
//   is_nan  : e all-ones, m != 0
module bf16_classify #(
    parameter int E = 8,
    parameter int M = 7
) (
    input  logic [E+M:0] word,
    output logic         s,
    output logic [E-1:0] e,
    output logic [M-1:0] m,
    output logic         is_zero,
    output logic         is_sub,
    output logic         is_inf,
    output logic         is_nan
);

    logic         exp_zero_s;
    logic         exp_ones_s;
    logic         man_zero_s;

    assign exp_zero_s = (word[E+M-1:M] == {E{1'b0}});
    assign exp_ones_s = (word[E+M-1:M] == {E{1'b1}});
    assign man_zero_s = (word[M-1:0] == {M{1'b0}});

    assign s       = word[E+M];
    assign e       = word[E+M-1:M];
    // Subnormals lose their mantissa so they read as signed zero downstream.
    assign m       = exp_zero_s ? {M{1'b0}} : word[M-1:0];

    assign is_zero = exp_zero_s & man_zero_s;
    assign is_sub  = exp_zero_s & ~man_zero_s;
    assign is_inf  = exp_ones_s & man_zero_s;
    assign is_nan  = exp_ones_s & ~man_zero_s;

endmodule

// File: rtl/bf16_add_operand_stage.sv
// bf16_add_operand_stage
// Registered valid/ready operand stage in front of the combinational bf16
// adder. Each accepted pair is unpacked, subnormals flushed to signed zero,
// and stored in a 2-entry skid buffer so ready_o is a pure flop output.
// Optional feature macro: BF16_SPECIAL_BYP_EN -- when defined, zero/inf/NaN
// operand combinations are resolved here and the replacement result travels
// with its pair (byp_*); otherwise byp_* are constant 0.
// Ports:
//   clk, nreset          : clock, asynchronous active-low reset
//   valid_i/ready_o      : upstream handshake, a_i/b_i raw operands
//   valid_o/ready_i      : downstream handshake toward the adder
//   sa_o..mb_o           : unpacked, flushed operand fields
//   byp_o, byp_s_o/e/m_o : special-case flag and replacement result
module bf16_add_operand_stage
    import bf16_pkg::*;
#(
    parameter int E = BF16_E,
    parameter int M = BF16_M
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [E+M:0] a_i,
    input  logic [E+M:0] b_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         sa_o,
    output logic         sb_o,
    output logic [E-1:0] ea_o,
    output logic [E-1:0] eb_o,
    output logic [M-1:0] ma_o,
    output logic [M-1:0] mb_o,
    output logic         byp_o,
    output logic         byp_s_o,
    output logic [E-1:0] byp_e_o,
    output logic [M-1:0] byp_m_o
);

    localparam int W  = 1 + E + M;
    localparam int DW = 2 * W;

    skid_state_t   state_r;
    logic          valid_r;
    logic          ready_r;
    logic [DW-1:0] main_r;
    logic [DW-1:0] skid_r;

    logic          a_sign_s, b_sign_s;
    logic [E-1:0]  a_exp_s,  b_exp_s;
    logic [M-1:0]  a_man_s,  b_man_s;
    logic          a_zero_s, b_zero_s;
    logic          a_sub_s,  b_sub_s;
    logic          a_inf_s,  b_inf_s;
    logic          a_nan_s,  b_nan_s;

    logic          in_xfer_s;
    logic          out_xfer_s;
    logic          load_main_s;
    logic          move_skid_s;
    logic          load_skid_s;
    logic [DW-1:0] data_new_s;

    bf16_classify #(.E(E), .M(M)) u_class_a (
        .word    (a_i),
        .s       (a_sign_s),
        .e       (a_exp_s),
        .m       (a_man_s),
        .is_zero (a_zero_s),
        .is_sub  (a_sub_s),
        .is_inf  (a_inf_s),
        .is_nan  (a_nan_s)
    );

    bf16_classify #(.E(E), .M(M)) u_class_b (
        .word    (b_i),
        .s       (b_sign_s),
        .e       (b_exp_s),
        .m       (b_man_s),
        .is_zero (b_zero_s),
        .is_sub  (b_sub_s),
        .is_inf  (b_inf_s),
        .is_nan  (b_nan_s)
    );

    assign data_new_s = {a_sign_s, a_exp_s, a_man_s, b_sign_s, b_exp_s, b_man_s};

    assign in_xfer_s   = valid_i & ready_r;
    assign out_xfer_s  = valid_r & ready_i;
    // ready_r is low in FULL, so in_xfer_s never fires there.
    assign load_main_s = in_xfer_s & ((state_r == EMPTY) | ((state_r == ONE) & out_xfer_s));
    assign load_skid_s = in_xfer_s & (state_r == ONE) & ~out_xfer_s;
    assign move_skid_s = out_xfer_s & (state_r == FULL);

    // Skid occupancy FSM with registered valid/ready.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    ready_r <= 1'b1;
                    if (in_xfer_s) begin
                        state_r <= ONE;
                        valid_r <= 1'b1;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ONE: begin
                    if (in_xfer_s && !out_xfer_s) begin
                        state_r <= FULL;
                        valid_r <= 1'b1;
                        ready_r <= 1'b0;
                    end else if (!in_xfer_s && out_xfer_s) begin
                        state_r <= EMPTY;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        valid_r <= 1'b1;
                        ready_r <= 1'b1;
                    end
                end
                FULL: begin
                    valid_r <= 1'b1;
                    if (out_xfer_s) begin
                        state_r <= ONE;
                        ready_r <= 1'b1;
                    end else begin
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Operand data for the main and skid entries.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            main_r <= {DW{1'b0}};
            skid_r <= {DW{1'b0}};
        end else begin
            if (load_main_s) begin
                main_r <= data_new_s;
            end else if (move_skid_s) begin
                main_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= data_new_s;
            end
        end
    end

    assign valid_o = valid_r;
    assign ready_o = ready_r;
    assign {sa_o, ea_o, ma_o, sb_o, eb_o, mb_o} = main_r;

`ifdef BF16_SPECIAL_BYP_EN
    localparam logic [W-1:0] CANON_NAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    logic          byp_new_s;
    logic [W-1:0]  byp_word_s;
    logic          a_fz_s, b_fz_s;
    logic          byp_main_r, byp_skid_r;
    logic [W-1:0]  byp_res_main_r, byp_res_skid_r;

    // Subnormals count as zero once flushed.
    assign a_fz_s = a_zero_s | a_sub_s;
    assign b_fz_s = b_zero_s | b_sub_s;

    // Special-operand resolution in priority order.
    always_comb begin
        byp_new_s  = 1'b0;
        byp_word_s = {W{1'b0}};
        if (a_nan_s || b_nan_s) begin
            byp_new_s  = 1'b1;
            byp_word_s = CANON_NAN;
        end else if (a_inf_s && b_inf_s && (a_sign_s != b_sign_s)) begin
            byp_new_s  = 1'b1;
            byp_word_s = CANON_NAN;
        end else if (a_inf_s) begin
            byp_new_s  = 1'b1;
            byp_word_s = {a_sign_s, a_exp_s, a_man_s};
        end else if (b_inf_s) begin
            byp_new_s  = 1'b1;
            byp_word_s = {b_sign_s, b_exp_s, b_man_s};
        end else if (a_fz_s && b_fz_s) begin
            // Round-toward-zero: the sum is -0 only when both are -0.
            byp_new_s  = 1'b1;
            byp_word_s = {a_sign_s & b_sign_s, {E{1'b0}}, {M{1'b0}}};
        end else if (a_fz_s) begin
            byp_new_s  = 1'b1;
            byp_word_s = {b_sign_s, b_exp_s, b_man_s};
        end else if (b_fz_s) begin
            byp_new_s  = 1'b1;
            byp_word_s = {a_sign_s, a_exp_s, a_man_s};
        end else begin
            byp_new_s  = 1'b0;
            byp_word_s = {W{1'b0}};
        end
    end

    // Bypass result follows its pair through main/skid.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            byp_main_r     <= 1'b0;
            byp_skid_r     <= 1'b0;
            byp_res_main_r <= {W{1'b0}};
            byp_res_skid_r <= {W{1'b0}};
        end else begin
            if (load_main_s) begin
                byp_main_r     <= byp_new_s;
                byp_res_main_r <= byp_word_s;
            end else if (move_skid_s) begin
                byp_main_r     <= byp_skid_r;
                byp_res_main_r <= byp_res_skid_r;
            end
            if (load_skid_s) begin
                byp_skid_r     <= byp_new_s;
                byp_res_skid_r <= byp_word_s;
            end
        end
    end

    assign byp_o = byp_main_r;
    assign {byp_s_o, byp_e_o, byp_m_o} = byp_res_main_r;
`else
    // Classification flags only feed the bypass logic; collected here so the
    // default build carries no dangling nets.
    logic unused_class_s;
    assign unused_class_s = ^{a_zero_s, a_sub_s, a_inf_s, a_nan_s,
                              b_zero_s, b_sub_s, b_inf_s, b_nan_s};

    assign byp_o   = 1'b0;
    assign byp_s_o = 1'b0;
    assign byp_e_o = {E{1'b0}};
    assign byp_m_o = {M{1'b0}};
`endif

endmodule

// File: tb/tb_bf16_add_operand_stage.sv
// tb_bf16_add_operand_stage
// Scoreboard bench for bf16_add_operand_stage. The driver pushes the expected
// unpacked pair (from a field-level reference model) whenever an input
// transfer happens; an independent monitor pops and compares on each output
// transfer and checks that held outputs stay stable. Honors
// BF16_SPECIAL_BYP_EN in the reference model.
module tb_bf16_add_operand_stage;
    import bf16_pkg::*;

    localparam int E = 8;
    localparam int M = 7;
    localparam int N_RAND = 10000;

    typedef logic [48:0] vec_t;

    logic         clk;
    logic         nreset;
    logic         valid_i;
    logic         ready_o;
    logic [15:0]  a_i;
    logic [15:0]  b_i;
    logic         valid_o;
    logic         ready_i;
    logic         sa_o, sb_o;
    logic [E-1:0] ea_o, eb_o;
    logic [M-1:0] ma_o, mb_o;
    logic         byp_o;
    logic         byp_s_o;
    logic [E-1:0] byp_e_o;
    logic [M-1:0] byp_m_o;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t dut_vec;
    vec_t held_vec;
    bit   hold_v = 1'b0;

    bf16_add_operand_stage #(.E(E), .M(M)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sa_o    (sa_o),
        .sb_o    (sb_o),
        .ea_o    (ea_o),
        .eb_o    (eb_o),
        .ma_o    (ma_o),
        .mb_o    (mb_o),
        .byp_o   (byp_o),
        .byp_s_o (byp_s_o),
        .byp_e_o (byp_e_o),
        .byp_m_o (byp_m_o)
    );

    assign dut_vec = {sa_o, ea_o, ma_o, sb_o, eb_o, mb_o, byp_o, byp_s_o, byp_e_o, byp_m_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: value-level view of a bf16 pair and the adder's special cases.
    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
        bf16_op_t    fa;
        bf16_op_t    fb;
        logic        byp;
        logic [15:0] r;
        fa.s = a[15];
        fa.e = a[14:7];
        fa.m = (a[14:7] == 8'd0) ? 7'd0 : a[6:0];
        fb.s = b[15];
        fb.e = b[14:7];
        fb.m = (b[14:7] == 8'd0) ? 7'd0 : b[6:0];
        byp  = 1'b0;
        r    = 16'h0000;
`ifdef BF16_SPECIAL_BYP_EN
        begin
            bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
            a_nan  = (fa.e == 8'hFF) && (fa.m != 7'd0);
            b_nan  = (fb.e == 8'hFF) && (fb.m != 7'd0);
            a_inf  = (fa.e == 8'hFF) && (fa.m == 7'd0);
            b_inf  = (fb.e == 8'hFF) && (fb.m == 7'd0);
            a_zero = (fa.e == 8'h00);
            b_zero = (fb.e == 8'h00);
            byp = 1'b1;
            if (a_nan || b_nan)                    r = 16'h7FC0;
            else if (a_inf && b_inf && fa.s != fb.s) r = 16'h7FC0;
            else if (a_inf)                         r = fa;
            else if (b_inf)                         r = fb;
            else if (a_zero && b_zero)              r = {fa.s & fb.s, 15'h0000};
            else if (a_zero)                        r = fb;
            else if (b_zero)                        r = fa;
            else begin
                byp = 1'b0;
                r   = 16'h0000;
            end
        end
`endif
        return {fa, fb, byp, r};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [7:0] e;
        logic [6:0] m;
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            default: e = 8'($urandom_range(1, 254));
        endcase
        m = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
        return {1'($urandom), e, m};
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (ready_o) begin
                exp_q.push_back(model(a, b));
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout a %h b %h not accepted", a, b);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk); #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 100 && (exp_q.size() != 0 || valid_o); k++) begin
            @(negedge clk);
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare on output transfer, check stability while stalled.
    always @(negedge clk) begin
        if (!nreset) begin
            hold_v = 1'b0;
        end else if (valid_o) begin
            if (hold_v) check("stable", 64'(dut_vec), 64'(held_vec));
            if (ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out got %h expected none", dut_vec);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    check("data", 64'(dut_vec), 64'(e));
                end
                hold_v = 1'b0;
            end else begin
                hold_v   = 1'b1;
                held_vec = dut_vec;
            end
        end else begin
            if (hold_v) check("valid_hold", {63'd0, valid_o}, 64'd1);
            hold_v = 1'b0;
        end
    end

    initial begin
        int sent;
        int cycles;
        nreset  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a_i     = 16'h0000;
        b_i     = 16'h0000;

        // Reset values
        #2;
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_data", 64'(dut_vec), 64'd0);
        #20 nreset = 1'b1;
        #1 check("ready_pre_edge", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        check("ready_after_rel", {63'd0, ready_o}, 64'd1);

        // Directed operand cases, one-cycle latency
        ready_i = 1'b1;
        send(16'h3F80, 16'h4000);
        idle();
        @(negedge clk);
        check("latency_valid", {63'd0, valid_o}, 64'd1);
        send(16'h0001, 16'h8040);
        send(16'h7F80, 16'hFF80);
        send(16'h7FC1, 16'h3F80);
        send(16'hFF80, 16'h8000);
        send(16'h0000, 16'h8000);
        idle();
        repeat (3) @(negedge clk);

        // Skid fill with downstream stalled
        @(posedge clk); #1;
        ready_i = 1'b0;
        send(16'h4040, 16'h4080);
        send(16'hC0A0, 16'h0005);
        @(posedge clk); #1;
        a_i = 16'h3C00;
        b_i = 16'hBC00;
        @(negedge clk);
        check("ready_full", {63'd0, ready_o}, 64'd0);
        check("valid_full", {63'd0, valid_o}, 64'd1);
        @(posedge clk); #1;
        ready_i = 1'b1;
        send(16'h3C00, 16'hBC00);
        drain();

        // Random traffic
        sent   = 0;
        cycles = 0;
        while (sent < N_RAND && cycles < 60000) begin
            @(posedge clk); #1;
            ready_i = ($urandom_range(0, 3) != 0);
            valid_i = ($urandom_range(0, 3) != 0);
            a_i     = rand_op();
            b_i     = rand_op();
            @(negedge clk);
            if (valid_i && ready_o) begin
                exp_q.push_back(model(a_i, b_i));
                sent++;
            end
            cycles++;
        end
        check("rand_count", 64'(sent), 64'(N_RAND));
        drain();

        // Reset while FULL
        @(posedge clk); #1;
        ready_i = 1'b0;
        send(16'h4100, 16'h4200);
        send(16'h4300, 16'h4400);
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("full_before_rst", {63'd0, ready_o}, 64'd0);
        #2 nreset = 1'b0;
        #1;
        exp_q.delete();
        check("rst_full_valid", {63'd0, valid_o}, 64'd0);
        check("rst_full_ready", {63'd0, ready_o}, 64'd0);
        check("rst_full_data", 64'(dut_vec), 64'd0);
        ready_i = 1'b1;
        @(negedge clk);
        #2 nreset = 1'b1;
        #1 check("rel_ready_low", {63'd0, ready_o}, 64'd0);
        @(posedge clk); #1;
        check("rel_ready_high", {63'd0, ready_o}, 64'd1);
        check("rel_no_stale", {63'd0, valid_o}, 64'd0);
        repeat (5) @(negedge clk);
        check("no_stale_later", {63'd0, valid_o}, 64'd0);

        // Traffic after reset still works
        send(16'h3F80, 16'h0000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
